// File: rtl/keypad_bcd_entry_ctrl.sv
// Keypad digit entry controller: debounces ten decimal key lines, rejects
// multi-key presses, shifts accepted digits into a packed-BCD accumulator and
// hands the finished number downstream over a valid/ready handshake.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | waiting for a key press or an enter request
//   DEB_PRESS | counting identical samples of the latched key pattern
//   WAIT_REL  | key accepted (or rejected), waiting for all keys released
//   DEB_REL   | counting consecutive all-released samples
//   HOLD      | number committed, out_valid high until the handshake
module keypad_bcd_entry_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [9:0]                   d_in,
    input  logic                         enter,
    input  logic                         clear,
    output logic [4*DIGITS-1:0]          bcd_out,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int NW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
    localparam logic [NW-1:0] DEB_C    = NW'(DEB_CYCLES);
    localparam logic [NW-1:0] CNT_ONE  = NW'(1);

    typedef enum logic [2:0] {
        IDLE, DEB_PRESS, WAIT_REL, DEB_REL, HOLD
    } state_t;

    state_t              state_q, state_n;
    logic [9:0]          key_q, key_n;
    logic [NW-1:0]       cnt_q, cnt_n;
    logic [4*DIGITS-1:0] bcd_q, bcd_n;
    logic [CW-1:0]       count_q, count_n;
    logic                err_q, err_n;
    logic                one_hot;
    logic [4*DIGITS-1:0] dig_ext;

    // Highest set line wins; only meaningful once the pattern is known one-hot.
    function automatic logic [3:0] encode(input logic [9:0] k);
        logic [3:0] e;
        e = '0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) e = 4'(i);
        end
        return e;
    endfunction

    assign one_hot = (key_q != '0) && ((key_q & (key_q - 10'd1)) == '0);

    // Next-state, accumulator and error-pulse logic.
    always_comb begin
        state_n        = state_q;
        key_n          = key_q;
        cnt_n          = cnt_q;
        bcd_n          = bcd_q;
        count_n        = count_q;
        err_n          = 1'b0;
        dig_ext        = '0;
        dig_ext[3:0]   = encode(key_q);
        if (clear) begin
            state_n = IDLE;
            bcd_n   = '0;
            count_n = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_in != '0) begin
                        key_n   = d_in;
                        cnt_n   = CNT_ONE;
                        state_n = DEB_PRESS;
                    end else if (enter && count_q != '0) begin
                        state_n = HOLD;
                    end
                end
                DEB_PRESS: begin
                    if (d_in != key_q) begin
                        state_n = IDLE;
                    end else if (cnt_q == DEB_C) begin
                        state_n = WAIT_REL;
                        if (!one_hot || count_q == DIGITS_C) begin
                            err_n = 1'b1;
                        end else begin
                            bcd_n   = (bcd_q << 4) | dig_ext;
                            count_n = count_q + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (d_in == '0) begin
                        cnt_n   = CNT_ONE;
                        state_n = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (d_in != '0) begin
                        state_n = WAIT_REL;
                    end else if (cnt_q == DEB_C) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    // out_valid is high throughout HOLD, so ready alone completes the handshake.
                    if (out_ready) begin
                        bcd_n   = '0;
                        count_n = '0;
                        state_n = WAIT_REL;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            key_q   <= key_n;
            cnt_q   <= cnt_n;
            bcd_q   <= bcd_n;
            count_q <= count_n;
            err_q   <= err_n;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_count = count_q;
    assign out_valid   = (state_q == HOLD);
    assign err         = err_q;

endmodule
